usb_cdc_echo_buffer: RTL and testbench



---
 rtl/usb_cdc_echo_buffer.sv | 182 ++++++++++++++++++
 tb/tb_usb_cdc_echo_buffer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_cdc_echo_buffer.sv
// usb_cdc_echo_buffer
// Buffered loopback between the usb_cdc_top receive stream and its send
// stream. Host bytes are stored in a FIFO and returned through a single
// output register that honours send_ready. In line mode bytes are held back
// until a terminator, a full FIFO or an idle timeout commits them.
// Dropped bytes raise a sticky overflow flag.
//
// Optional build macro: USB_CDC_ECHO_STATS_EN adds rx_bytes, tx_bytes and
// drop_bytes statistics outputs.

module usb_cdc_echo_buffer #(
    parameter int         DEPTH_LOG2    = 10,
    parameter int         LINE_MODE     = 0,
    parameter logic [7:0] TERM_CHAR     = 8'h0A,
    parameter int         FLUSH_TIMEOUT = 600000
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [7:0]            recv_data,
    input  logic                  recv_valid,
    output logic [7:0]            send_data,
    output logic                  send_valid,
    input  logic                  send_ready,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  overflow,
    input  logic                  overflow_clr
`ifdef USB_CDC_ECHO_STATS_EN
    ,
    output logic [31:0]           rx_bytes,
    output logic [31:0]           tx_bytes,
    output logic [15:0]           drop_bytes
`endif
);

    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int TW    = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT + 1) : 1;

    logic [7:0]    mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] cmt_ptr_r;
    logic [PW-1:0] count_r;
    logic [TW-1:0] tmo_r;
    logic [7:0]    send_data_r;
    logic          send_valid_r;
    logic          overflow_r;

    logic          full_s;
    logic          avail_s;
    logic          pop_s;
    logic          push_s;
    logic          drop_s;
    logic          uncommitted_s;
    logic          commit_s;
    logic [PW-1:0] wr_next_s;
    logic [PW-1:0] count_next_s;

    // FIFO status, handshake decisions and line-mode commit detection
    always_comb begin
        full_s        = (wr_ptr_r[PW-1] != rd_ptr_r[PW-1]) &&
                        (wr_ptr_r[PW-2:0] == rd_ptr_r[PW-2:0]);
        uncommitted_s = (cmt_ptr_r != wr_ptr_r);
        if (LINE_MODE != 0) begin
            avail_s = (rd_ptr_r != cmt_ptr_r);
        end else begin
            avail_s = (rd_ptr_r != wr_ptr_r);
        end
        pop_s  = avail_s && (!send_valid_r || send_ready);
        // a pop on the same edge frees the slot a full FIFO needs
        push_s = recv_valid && (!full_s || pop_s);
        drop_s = recv_valid && !push_s;
        if (push_s) begin
            wr_next_s = wr_ptr_r + PW'(1);
        end else begin
            wr_next_s = wr_ptr_r;
        end
        count_next_s = count_r + PW'(push_s) - PW'(pop_s);
        if (LINE_MODE != 0) begin
            // terminator, a FIFO that becomes full, or an expired idle timer
            commit_s = (push_s && (recv_data == TERM_CHAR)) ||
                       (count_next_s == PW'(DEPTH)) ||
                       (uncommitted_s && (tmo_r == TW'(1)));
        end else begin
            // byte echo: everything written is immediately eligible
            commit_s = 1'b1;
        end
    end

    // FIFO storage write port (no reset so it maps onto block RAM)
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[PW-2:0]] <= recv_data;
        end
    end

    // Pointers, occupancy, commit pointer and idle timeout counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            cmt_ptr_r <= '0;
            count_r   <= '0;
            tmo_r     <= '0;
        end else begin
            wr_ptr_r <= wr_next_s;
            count_r  <= count_next_s;
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            if (commit_s) begin
                cmt_ptr_r <= wr_next_s;
                tmo_r     <= '0;
            end else if (push_s) begin
                tmo_r <= TW'(FLUSH_TIMEOUT);
            end else if (uncommitted_s && (tmo_r != '0)) begin
                tmo_r <= tmo_r - TW'(1);
            end else if (!uncommitted_s) begin
                tmo_r <= '0;
            end
        end
    end

    // Output register: the RAM read register doubles as send_data
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            send_valid_r <= 1'b0;
            send_data_r  <= 8'h00;
        end else if (pop_s) begin
            send_valid_r <= 1'b1;
            send_data_r  <= mem_r[rd_ptr_r[PW-2:0]];
        end else if (send_ready) begin
            send_valid_r <= 1'b0;
        end
    end

    // Sticky overflow flag; a drop on the same edge as a clear keeps it set
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (overflow_clr) begin
            overflow_r <= 1'b0;
        end
    end

`ifdef USB_CDC_ECHO_STATS_EN
    logic [31:0] rx_bytes_r;
    logic [31:0] tx_bytes_r;
    logic [15:0] drop_bytes_r;

    // Traffic statistics; drop counter saturates rather than wrapping
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_bytes_r   <= 32'd0;
            tx_bytes_r   <= 32'd0;
            drop_bytes_r <= 16'd0;
        end else begin
            if (push_s) begin
                rx_bytes_r <= rx_bytes_r + 32'd1;
            end
            if (send_valid_r && send_ready) begin
                tx_bytes_r <= tx_bytes_r + 32'd1;
            end
            if (drop_s && (drop_bytes_r != 16'hFFFF)) begin
                drop_bytes_r <= drop_bytes_r + 16'd1;
            end
        end
    end

    assign rx_bytes   = rx_bytes_r;
    assign tx_bytes   = tx_bytes_r;
    assign drop_bytes = drop_bytes_r;
`endif

    assign send_data  = send_data_r;
    assign send_valid = send_valid_r;
    assign fifo_count = count_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_usb_cdc_echo_buffer.sv
// Bench for usb_cdc_echo_buffer: four instances with different parameters,
// directed stimulus, and a scoreboard queue drained by a monitor process.
// Instance 0: byte mode, default depth. Instance 1: byte mode, depth 4.
// Instance 2: line mode, no timeout. Instance 3: line mode, timeout 100.

module tb_usb_cdc_echo_buffer;

    logic       clk;
    logic       rstn;
    logic [7:0] rdat [4];
    logic       rval [4];
    logic [7:0] sdat [4];
    logic       sval [4];
    logic       srdy [4];
    logic       ovf  [4];
    logic       oclr [4];
    logic [10:0] fc0;
    logic [2:0]  fc1;
    logic [10:0] fc2;
    logic [10:0] fc3;

    int total = 0;
    int bad   = 0;

    // expected output entries: {instance id, data byte}
    logic [9:0] exp_q [$];

    logic       held [4];
    logic [7:0] hdat [4];

    usb_cdc_echo_buffer #(.DEPTH_LOG2(10), .LINE_MODE(0)) u_big (
        .clk(clk), .rstn(rstn), .recv_data(rdat[0]), .recv_valid(rval[0]),
        .send_data(sdat[0]), .send_valid(sval[0]), .send_ready(srdy[0]),
        .fifo_count(fc0), .overflow(ovf[0]), .overflow_clr(oclr[0]));

    usb_cdc_echo_buffer #(.DEPTH_LOG2(2), .LINE_MODE(0)) u_small (
        .clk(clk), .rstn(rstn), .recv_data(rdat[1]), .recv_valid(rval[1]),
        .send_data(sdat[1]), .send_valid(sval[1]), .send_ready(srdy[1]),
        .fifo_count(fc1), .overflow(ovf[1]), .overflow_clr(oclr[1]));

    usb_cdc_echo_buffer #(.DEPTH_LOG2(10), .LINE_MODE(1), .FLUSH_TIMEOUT(0)) u_line0 (
        .clk(clk), .rstn(rstn), .recv_data(rdat[2]), .recv_valid(rval[2]),
        .send_data(sdat[2]), .send_valid(sval[2]), .send_ready(srdy[2]),
        .fifo_count(fc2), .overflow(ovf[2]), .overflow_clr(oclr[2]));

    usb_cdc_echo_buffer #(.DEPTH_LOG2(10), .LINE_MODE(1), .FLUSH_TIMEOUT(100)) u_line_t (
        .clk(clk), .rstn(rstn), .recv_data(rdat[3]), .recv_valid(rval[3]),
        .send_data(sdat[3]), .send_valid(sval[3]), .send_ready(srdy[3]),
        .fifo_count(fc3), .overflow(ovf[3]), .overflow_clr(oclr[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // one-cycle strobe; called at posedge+1 so consecutive calls are back-to-back
    task automatic send(input int k, input logic [7:0] d);
        rdat[k] = d;
        rval[k] = 1'b1;
        @(posedge clk);
        #1;
        rval[k] = 1'b0;
    endtask

    task automatic drain(input int k, input int lim, input logic toggle);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < lim) begin
            @(posedge clk);
            #1;
            if (toggle) srdy[k] = !srdy[k];
            n++;
        end
        chk("drain", exp_q.size(), 0);
        srdy[k] = 1'b1;
    endtask

    // monitor: checks every transfer against the scoreboard and holding rule
    initial begin
        logic [9:0] e;
        for (int k = 0; k < 4; k++) begin
            held[k] = 1'b0;
            hdat[k] = 8'h00;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (rstn !== 1'b1) begin
                    held[k] = 1'b0;
                end else begin
                    if (held[k]) begin
                        total++;
                        if (sval[k] !== 1'b1 || sdat[k] !== hdat[k]) begin
                            bad++;
                            $display("FAIL hold%0d: got valid=%0b data=%h want valid=1 data=%h",
                                     k, sval[k], sdat[k], hdat[k]);
                        end
                    end
                    if (sval[k] === 1'b1 && srdy[k] === 1'b1) begin
                        total++;
                        if (exp_q.size() == 0) begin
                            bad++;
                            $display("FAIL out%0d: got unexpected byte %h want none", k, sdat[k]);
                        end else begin
                            e = exp_q.pop_front();
                            if (e !== {2'(k), sdat[k]}) begin
                                bad++;
                                $display("FAIL out%0d: got inst %0d data %h want inst %0d data %h",
                                         k, k, sdat[k], e[9:8], e[7:0]);
                            end
                        end
                    end
                    held[k] = (sval[k] === 1'b1) && (srdy[k] !== 1'b1);
                    hdat[k] = sdat[k];
                end
            end
        end
    end

    initial begin
        int cnt;
        rstn = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rdat[k] = 8'h00; rval[k] = 1'b0; srdy[k] = 1'b0; oclr[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        // reset state
        for (int k = 0; k < 4; k++) begin
            chk("rst_valid", int'(sval[k]), 0);
            chk("rst_data", int'(sdat[k]), 0);
            chk("rst_ovf", int'(ovf[k]), 0);
        end
        chk("rst_fc0", int'(fc0), 0);
        chk("rst_fc1", int'(fc1), 0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // single byte echo latency
        srdy[0] = 1'b1;
        exp_q.push_back({2'd0, 8'h41});
        send(0, 8'h41);
        @(negedge clk);
        chk("lat_valid_t", int'(sval[0]), 0);
        chk("lat_fc_t", int'(fc0), 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("lat_valid_t1", int'(sval[0]), 1);
        chk("lat_data_t1", int'(sdat[0]), 'h41);
        chk("lat_fc_t1", int'(fc0), 0);
        @(posedge clk);
        #1;

        // 16-byte burst with send_ready toggling
        for (int i = 0; i < 16; i++) begin
            srdy[0] = (i % 2 == 0);
            exp_q.push_back({2'd0, 8'(8'h80 + i)});
            send(0, 8'(8'h80 + i));
        end
        drain(0, 60, 1'b1);

        // overflow on the depth-4 instance, clear and drop on the same edge
        srdy[1] = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            exp_q.push_back({2'd1, 8'(i)});
            send(1, 8'(i));
        end
        oclr[1] = 1'b1;
        send(1, 8'h06);
        oclr[1] = 1'b0;
        @(negedge clk);
        chk("ovf_fc", int'(fc1), 4);
        chk("ovf_head", int'(sdat[1]), 1);
        chk("ovf_valid", int'(sval[1]), 1);
        chk("ovf_flag", int'(ovf[1]), 1);
        @(posedge clk);
        #1;
        srdy[1] = 1'b1;
        drain(1, 20, 1'b0);
        chk("ovf_fc_after", int'(fc1), 0);
        chk("ovf_sticky", int'(ovf[1]), 1);
        oclr[1] = 1'b1;
        @(posedge clk);
        #1;
        oclr[1] = 1'b0;
        @(negedge clk);
        chk("ovf_clr", int'(ovf[1]), 0);
        @(posedge clk);
        #1;

        // line mode, terminator commit
        srdy[2] = 1'b1;
        send(2, 8'h61);
        send(2, 8'h62);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (sval[2] !== 1'b0) cnt++;
            @(posedge clk);
            #1;
        end
        chk("line_hold", cnt, 0);
        chk("line_fc", int'(fc2), 2);
        exp_q.push_back({2'd2, 8'h61});
        exp_q.push_back({2'd2, 8'h62});
        exp_q.push_back({2'd2, 8'h0A});
        send(2, 8'h0A);
        drain(2, 10, 1'b0);

        // line mode, timeout commit
        srdy[3] = 1'b1;
        send(3, 8'h78);
        send(3, 8'h79);
        send(3, 8'h7A);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sval[3] !== 1'b0) cnt++;
            @(posedge clk);
            #1;
        end
        chk("tmo_hold", cnt, 0);
        chk("tmo_fc", int'(fc3), 3);
        @(negedge clk);
        chk("tmo_edge100", int'(sval[3]), 0);
        exp_q.push_back({2'd3, 8'h78});
        exp_q.push_back({2'd3, 8'h79});
        exp_q.push_back({2'd3, 8'h7A});
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("tmo_edge101", int'(sval[3]), 1);
        chk("tmo_first", int'(sdat[3]), 'h78);
        @(posedge clk);
        #1;
        drain(3, 10, 1'b0);

        // asynchronous reset with data buffered and output valid
        srdy[0] = 1'b0;
        for (int i = 0; i < 5; i++) send(0, 8'(8'hB0 + i));
        @(negedge clk);
        chk("pre_rst_fc", int'(fc0), 4);
        chk("pre_rst_valid", int'(sval[0]), 1);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        chk("mid_rst_valid", int'(sval[0]), 0);
        chk("mid_rst_fc", int'(fc0), 0);
        chk("mid_rst_ovf", int'(ovf[0]), 0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        srdy[0] = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back({2'd0, 8'hC3});
        send(0, 8'hC3);
        drain(0, 10, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_fc", int'(fc0), 0);
        chk("post_rst_idle", int'(sval[0]), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
